mips_pipe_ctrl: RTL and testbench

//  Parametrised pipeline control for the MIPS 5-stage core; replaces the stall-only hazard detector.

---
 rtl/mips_pipe_pkg.sv | 25 ++
 rtl/mips_sat_counter.sv | 18 +
 rtl/mips_pipe_ctrl.sv | 94 +++++++++
 tb/tb_mips_pipe_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared types, constants and helpers for the MIPS pipeline control
package mips_pipe_pkg;
   localparam int RN_MAX = 8;
   localparam int FWD_RF = 0;
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05;
   localparam logic [5:0] OP_LW = 6'h23;
   localparam logic [5:0] FN_JR = 6'h08;
   typedef struct packed {
      logic valid;
      logic wr_en;
      logic [RN_MAX-1:0] wr_num;
      logic is_load;
   } sb_entry_t;
   function automatic int fwd_sel_w(input int stages);
      return $clog2(stages + 1);
   endfunction
   function automatic logic op_is_load(input logic [5:0] op);
      return op == OP_LW;
   endfunction
   function automatic logic op_is_branch(input logic [5:0] op, input logic [5:0] fn);
      return op == OP_BEQ || op == OP_BNE || (op == OP_SPECIAL && fn == FN_JR);
   endfunction
endpackage

// File: rtl/mips_sat_counter.sv
// mips_sat_counter: saturating event counter with synchronous clear
// Ports: clk, rst (async, active high), clear_i (sync clear), inc_i (count one event), cnt_o (value).
module mips_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clear_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/mips_pipe_ctrl.sv
// mips_pipe_ctrl: scoreboard-based hazard, forwarding, flush and halt control for the 5-stage MIPS core
// Ports: clk, rst (async, active high); ID-stage instruction info (*_i); redirect_i, halt_i;
//   pc_en_o, ifid_en_o, ifid_clear_o, idex_clear_o, fwd_a_sel_o/fwd_b_sel_o (0 = regfile, k = stage k),
//   halted_o, stall_cnt_o, flush_cnt_o.
// Build option: define MIPS_PIPE_FWD_EN for forwarding; otherwise stall-only, selects tied to regfile.
module mips_pipe_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int STAGES = 3,
   parameter int RN_W = 5,
   parameter int CNT_W = 32,
   localparam int FS_W = fwd_sel_w(STAGES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid_i,
   input  logic [RN_W-1:0]  id_r1_num_i,
   input  logic             id_r1_used_i,
   input  logic [RN_W-1:0]  id_r2_num_i,
   input  logic             id_r2_used_i,
   input  logic             id_wr_en_i,
   input  logic [RN_W-1:0]  id_wr_num_i,
   input  logic             id_is_load_i,
   input  logic             id_is_branch_i,
   input  logic             redirect_i,
   input  logic             halt_i,
   output logic             pc_en_o,
   output logic             ifid_en_o,
   output logic             ifid_clear_o,
   output logic             idex_clear_o,
   output logic [FS_W-1:0]  fwd_a_sel_o,
   output logic [FS_W-1:0]  fwd_b_sel_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);
`ifdef MIPS_PIPE_FWD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif
   sb_entry_t sb_q [1:STAGES];
   sb_entry_t sb_d [1:STAGES];
   logic [FS_W-1:0] a_k, b_k;
   logic a_ld, b_ld, drained, fwd_haz, any_haz, hz, stop;
   function automatic logic hit(input sb_entry_t e, input logic [RN_W-1:0] src, input logic used);
      return used && src != '0 && e.valid && e.wr_en && e.wr_num == RN_MAX'(src);
   endfunction
   // Scan oldest to youngest so the youngest producer overwrites; the WB stage is write-through.
   always_comb begin
      a_k = '0;
      b_k = '0;
      a_ld = 1'b0;
      b_ld = 1'b0;
      drained = 1'b1;
      for (int k = STAGES - 1; k >= 1; k--) begin
         if (hit(sb_q[k], id_r1_num_i, id_r1_used_i)) begin
            a_k = FS_W'(k);
            a_ld = sb_q[k].is_load;
         end
         if (hit(sb_q[k], id_r2_num_i, id_r2_used_i)) begin
            b_k = FS_W'(k);
            b_ld = sb_q[k].is_load;
         end
      end
      for (int k = 1; k <= STAGES; k++) drained = drained && !sb_q[k].valid;
   end
   // Load data is not ready until after MEM; branches compare in ID so they need one more stage of slack.
   assign fwd_haz = (a_k == FS_W'(1) && (a_ld || id_is_branch_i)) || (a_k == FS_W'(2) && a_ld && id_is_branch_i) ||
                    (b_k == FS_W'(1) && (b_ld || id_is_branch_i)) || (b_k == FS_W'(2) && b_ld && id_is_branch_i);
   assign any_haz = a_k != '0 || b_k != '0;
   assign hz = id_valid_i && (FWD_ON ? fwd_haz : any_haz);
   assign stop = hz || halt_i;
   assign pc_en_o = !stop;
   assign ifid_en_o = !stop;
   assign idex_clear_o = stop;
   assign ifid_clear_o = redirect_i && !stop;
   assign halted_o = halt_i && drained;
   assign fwd_a_sel_o = FWD_ON ? a_k : FS_W'(FWD_RF);
   assign fwd_b_sel_o = FWD_ON ? b_k : FS_W'(FWD_RF);
   always_comb begin
      sb_d[1] = '{valid: id_valid_i && !stop, wr_en: id_wr_en_i, wr_num: RN_MAX'(id_wr_num_i), is_load: id_is_load_i};
      for (int k = 2; k <= STAGES; k++) sb_d[k] = sb_q[k-1];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) for (int k = 1; k <= STAGES; k++) sb_q[k] <= '0;
      else sb_q <= sb_d;
   mips_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk(clk), .rst(rst), .clear_i(1'b0), .inc_i(hz), .cnt_o(stall_cnt_o)
   );
   mips_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk(clk), .rst(rst), .clear_i(1'b0), .inc_i(ifid_clear_o), .cnt_o(flush_cnt_o)
   );
endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// tb_mips_pipe_ctrl: directed scenarios plus randomized run against a queue-based pipeline model
module tb_mips_pipe_ctrl;
`ifdef MIPS_PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int ST = 3;
   logic clk = 1'b0, rst;
   logic id_valid, u1, u2, we, ld, br, redir, halt;
   logic [4:0] r1, r2, wn;
   logic pc_en, ifid_en, ifid_clear, idex_clear, halted;
   logic [1:0] fa, fb;
   logic [31:0] sc, fc;
   logic pc_en4, ifid_en4, ifid_clear4, idex_clear4, halted4;
   logic [1:0] fa4, fb4;
   logic [3:0] sc4, fc4;
   int n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   mips_pipe_ctrl #(.STAGES(ST), .RN_W(5), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_r1_num_i(r1), .id_r1_used_i(u1),
      .id_r2_num_i(r2), .id_r2_used_i(u2), .id_wr_en_i(we), .id_wr_num_i(wn), .id_is_load_i(ld),
      .id_is_branch_i(br), .redirect_i(redir), .halt_i(halt), .pc_en_o(pc_en), .ifid_en_o(ifid_en),
      .ifid_clear_o(ifid_clear), .idex_clear_o(idex_clear), .fwd_a_sel_o(fa), .fwd_b_sel_o(fb),
      .halted_o(halted), .stall_cnt_o(sc), .flush_cnt_o(fc)
   );
   mips_pipe_ctrl #(.STAGES(ST), .RN_W(5), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_r1_num_i(r1), .id_r1_used_i(u1),
      .id_r2_num_i(r2), .id_r2_used_i(u2), .id_wr_en_i(we), .id_wr_num_i(wn), .id_is_load_i(ld),
      .id_is_branch_i(br), .redirect_i(redir), .halt_i(halt), .pc_en_o(pc_en4), .ifid_en_o(ifid_en4),
      .ifid_clear_o(ifid_clear4), .idex_clear_o(idex_clear4), .fwd_a_sel_o(fa4), .fwd_b_sel_o(fb4),
      .halted_o(halted4), .stall_cnt_o(sc4), .flush_cnt_o(fc4)
   );
   task automatic set_in(input bit v, input int a, input bit ua, input int b, input bit ub, input bit w,
                         input int n, input bit l, input bit bb, input bit rd, input bit h);
      id_valid = v; r1 = 5'(a); u1 = ua; r2 = 5'(b); u2 = ub; we = w; wn = 5'(n);
      ld = l; br = bb; redir = rd; halt = h;
   endtask
   task automatic drive(input bit v, input int a, input bit ua, input int b, input bit ub, input bit w,
                        input int n, input bit l, input bit bb, input bit rd, input bit h);
      @(negedge clk);
      set_in(v, a, ua, b, ub, w, n, l, bb, rd, h);
      #1;
   endtask
   task automatic do_reset;
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask
   task automatic test_reset;
      do_reset;
      drive(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0);
      drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({pc_en, ifid_en, ifid_clear, idex_clear, halted} !== 5'b11000) begin
         n_bad++; $display("FAIL reset_ctrl: got %b want 11000", {pc_en, ifid_en, ifid_clear, idex_clear, halted});
      end
      n_cmp++;
      if ({fa, fb} !== 4'd0) begin n_bad++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", fa, fb); end
      n_cmp++;
      if (sc !== 32'd0 || fc !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", sc, fc); end
      rst = 1'b0;
   endtask
   task automatic test_alu_forward;
      int ns = FWD ? 0 : 2;
      do_reset;
      drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      n_cmp++;
      if (pc_en !== 1'b1) begin n_bad++; $display("FAIL alu_prod_pc_en: got %b want 1", pc_en); end
      drive(1, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0);
      for (int s = 0; s < ns; s++) begin
         n_cmp++;
         if (pc_en !== 1'b0 || idex_clear !== 1'b1 || fa !== 2'd0) begin
            n_bad++; $display("FAIL alu_stall%0d: got pc_en=%b idex_clear=%b fa=%0d want 0 1 0", s, pc_en, idex_clear, fa);
         end
         drive(1, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0);
      end
      n_cmp++;
      if (pc_en !== 1'b1 || fa !== (FWD ? 2'd1 : 2'd0)) begin
         n_bad++; $display("FAIL alu_fwd1: got pc_en=%b fa=%0d want 1 %0d", pc_en, fa, FWD ? 1 : 0);
      end
      n_cmp++;
      if (sc !== 32'(ns)) begin n_bad++; $display("FAIL alu_stall_cnt: got %0d want %0d", sc, ns); end
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pc_en !== 1'b1 || fa !== (FWD && ns == 0 ? 2'd2 : 2'd0)) begin
         n_bad++; $display("FAIL alu_fwd2: got pc_en=%b fa=%0d want 1 %0d", pc_en, fa, FWD ? 2 : 0);
      end
   endtask
   task automatic test_load_use;
      int ns = FWD ? 1 : 2;
      do_reset;
      drive(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
      drive(1, 3, 1, 0, 0, 1, 4, 0, 0, 0, 0);
      for (int s = 0; s < ns; s++) begin
         n_cmp++;
         if (pc_en !== 1'b0 || ifid_en !== 1'b0 || idex_clear !== 1'b1) begin
            n_bad++; $display("FAIL load_stall%0d: got pc_en=%b ifid_en=%b idex_clear=%b want 0 0 1", s, pc_en, ifid_en, idex_clear);
         end
         drive(1, 3, 1, 0, 0, 1, 4, 0, 0, 0, 0);
      end
      n_cmp++;
      if (pc_en !== 1'b1 || idex_clear !== 1'b0 || fa !== (FWD ? 2'd2 : 2'd0)) begin
         n_bad++; $display("FAIL load_fwd: got pc_en=%b idex_clear=%b fa=%0d want 1 0 %0d", pc_en, idex_clear, fa, FWD ? 2 : 0);
      end
      n_cmp++;
      if (sc !== 32'(ns)) begin n_bad++; $display("FAIL load_stall_cnt: got %0d want %0d", sc, ns); end
   endtask
   task automatic test_branch;
      int ns = FWD ? 1 : 2;
      do_reset;
      drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
      drive(1, 5, 1, 0, 1, 0, 0, 0, 1, 1, 0);
      for (int s = 0; s < ns; s++) begin
         n_cmp++;
         if (pc_en !== 1'b0 || ifid_clear !== 1'b0 || idex_clear !== 1'b1) begin
            n_bad++; $display("FAIL br_stall%0d: got pc_en=%b ifid_clear=%b idex_clear=%b want 0 0 1", s, pc_en, ifid_clear, idex_clear);
         end
         drive(1, 5, 1, 0, 1, 0, 0, 0, 1, 1, 0);
      end
      n_cmp++;
      if (ifid_clear !== 1'b1 || fa !== (FWD ? 2'd2 : 2'd0) || fb !== 2'd0) begin
         n_bad++; $display("FAIL br_resolve: got ifid_clear=%b fa=%0d fb=%0d want 1 %0d 0", ifid_clear, fa, fb, FWD ? 2 : 0);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (fc !== 32'd1 || sc !== 32'(ns)) begin
         n_bad++; $display("FAIL br_counts: got flush=%0d stall=%0d want 1 %0d", fc, sc, ns);
      end
   endtask
   task automatic test_zero_reg;
      do_reset;
      drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      drive(1, 0, 1, 0, 1, 1, 6, 0, 1, 0, 0);
      n_cmp++;
      if (pc_en !== 1'b1 || fa !== 2'd0 || fb !== 2'd0) begin
         n_bad++; $display("FAIL zero_reg: got pc_en=%b fa=%0d fb=%0d want 1 0 0", pc_en, fa, fb);
      end
      drive(1, 0, 0, 6, 0, 0, 0, 0, 1, 0, 0);
      n_cmp++;
      if (pc_en !== 1'b1 || fb !== 2'd0) begin
         n_bad++; $display("FAIL unused_src: got pc_en=%b fb=%0d want 1 0", pc_en, fb);
      end
   endtask
   task automatic test_halt;
      do_reset;
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 1, 7 + i, 0, 0, 0, 0);
      for (int c = 0; c < 4; c++) begin
         drive(1, 0, 0, 0, 0, 1, 10, 0, 1, 1, 1);
         n_cmp++;
         if (pc_en !== 1'b0 || idex_clear !== 1'b1 || ifid_clear !== 1'b0 || halted !== (c == 3)) begin
            n_bad++; $display("FAIL halt_c%0d: got pc_en=%b idex_clear=%b ifid_clear=%b halted=%b want 0 1 0 %0d",
                              c, pc_en, idex_clear, ifid_clear, halted, c == 3);
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pc_en !== 1'b1 || halted !== 1'b0 || fc !== 32'd0) begin
         n_bad++; $display("FAIL halt_resume: got pc_en=%b halted=%b flush=%0d want 1 0 0", pc_en, halted, fc);
      end
   endtask
   task automatic test_rst_mid_drain;
      do_reset;
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 1, 11 + i, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (halted !== 1'b0) begin n_bad++; $display("FAIL drain_busy: got halted=%b want 0", halted); end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (halted !== 1'b1 || pc_en !== 1'b0) begin
         n_bad++; $display("FAIL rst_drain: got halted=%b pc_en=%b want 1 0", halted, pc_en);
      end
      rst = 1'b0;
   endtask
   task automatic test_saturation;
      int pairs = FWD ? 20 : 10;
      int ns = FWD ? 1 : 2;
      do_reset;
      for (int p = 0; p < pairs; p++) begin
         drive(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
         for (int s = 0; s <= ns; s++) drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (sc !== 32'd20) begin n_bad++; $display("FAIL sat_wide: got %0d want 20", sc); end
      n_cmp++;
      if (sc4 !== 4'd15) begin n_bad++; $display("FAIL sat_narrow: got %0d want 15", sc4); end
   endtask
   typedef struct {bit v; bit w; int n; bit l;} inst_t;
   task automatic test_random;
      inst_t pipe[$];
      longint e_sc = 0, e_fc = 0;
      do_reset;
      for (int i = 0; i < ST; i++) pipe.push_back('{0, 0, 0, 0});
      for (int cyc = 0; cyc < 400; cyc++) begin
         bit v = $urandom_range(9) < 8, a_u = $urandom_range(1), b_u = $urandom_range(1);
         int a = $urandom_range(3), b = $urandom_range(3), n = $urandom_range(3);
         bit w = $urandom_range(1), l = w && $urandom_range(2) == 0, bb = $urandom_range(4) == 0;
         bit rd = $urandom_range(6) == 0, h = $urandom_range(9) == 0;
         int ka = 0, kb = 0;
         bit hz, stop, empty = 1;
         drive(v, a, a_u, b, b_u, w, n, l, bb, rd, h);
         for (int age = ST - 1; age >= 1; age--) begin
            if (a_u && a != 0 && pipe[age-1].v && pipe[age-1].w && pipe[age-1].n == a) ka = age;
            if (b_u && b != 0 && pipe[age-1].v && pipe[age-1].w && pipe[age-1].n == b) kb = age;
         end
         foreach (pipe[i]) if (pipe[i].v) empty = 0;
         if (FWD)
            hz = (ka == 1 && (pipe[0].l || bb)) || (ka == 2 && bb && pipe[1].l) ||
                 (kb == 1 && (pipe[0].l || bb)) || (kb == 2 && bb && pipe[1].l);
         else
            hz = ka != 0 || kb != 0;
         hz = hz && v;
         stop = hz || h;
         n_cmp++;
         if ({pc_en, ifid_en, idex_clear, ifid_clear, halted} !== {!stop, !stop, stop, rd && !stop, h && empty}) begin
            n_bad++; $display("FAIL rnd_ctrl@%0d: got %b want %b", cyc, {pc_en, ifid_en, idex_clear, ifid_clear, halted},
                              {!stop, !stop, stop, rd && !stop, h && empty});
         end
         n_cmp++;
         if (fa !== 2'(FWD ? ka : 0) || fb !== 2'(FWD ? kb : 0)) begin
            n_bad++; $display("FAIL rnd_fwd@%0d: got %0d/%0d want %0d/%0d", cyc, fa, fb, FWD ? ka : 0, FWD ? kb : 0);
         end
         n_cmp++;
         if (sc !== 32'(e_sc) || fc !== 32'(e_fc)) begin
            n_bad++; $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", cyc, sc, fc, e_sc, e_fc);
         end
         @(posedge clk);
         pipe.push_front('{v && !stop, w, n, l});
         void'(pipe.pop_back());
         e_sc += hz;
         e_fc += rd && !stop;
      end
   endtask
   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      test_reset;
      test_alu_forward;
      test_load_use;
      test_branch;
      test_zero_reg;
      test_halt;
      test_rst_mid_drain;
      test_saturation;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL timeout: got no completion want completion");
      $fatal(1, "timeout");
   end
endmodule
